// File: rtl/row_dot_if.sv
// Row-streaming convolution bus between the convolution driver (master) and
// the row dot-product responder (slave).
interface row_dot_if #(
  parameter int N = 31,
  parameter int n = 3
);
  logic                 run;
  logic [(N+1)*n-1:0]   arr1;
  logic [(N+1)*n-1:0]   arr2;
  logic [6:0]           flg;
  logic [N:0]           dpin;
  logic                 out_valid;

  modport master (output run, arr1, arr2, input flg, dpin, out_valid);
  modport slave  (input run, arr1, arr2, output flg, dpin, out_valid);
endinterface

// File: rtl/row_dot_engine.sv
// Responder for the row-streaming convolution bus: owns the phase counter and
// returns each captured row's n-lane dot product after 2n-1 cycles.
module row_dot_engine #(
  parameter int N = 31,
  parameter int n = 3
) (
  input  logic      clk,
  input  logic      rst,
  row_dot_if.slave  bus
);
  localparam int W    = N + 1;
  localparam int S    = 2 * n - 1;
  localparam int LAST = 3 * n - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [6:0]         flg_q, flg_d;
  logic               cap;

  logic signed [W-1:0] prod_q [1:n][0:n-1];
  logic signed [W-1:0] prod_d [1:n][0:n-1];
  logic signed [W-1:0] sum_q  [1:S];
  logic signed [W-1:0] sum_d  [1:S];
  logic                vld_q  [1:S];
  logic                vld_d  [1:S];
  logic signed [W-1:0] dpin_q, dpin_d;
  logic                out_valid_q, out_valid_d;

  // Product kept to the low W bits; the row sum wraps modulo 2^W.
  function automatic logic signed [W-1:0] mul_trunc(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
    mul_trunc = a * b;
  endfunction

  always_comb begin
    state_d = state_q;
    flg_d   = flg_q;
    unique case (state_q)
      IDLE: begin
        flg_d = '0;
        if (bus.run) state_d = RUN;
      end
      RUN: begin
        if (flg_q == 7'(LAST)) begin
          flg_d = '0;
          if (!bus.run) state_d = IDLE;
        end else begin
          flg_d = flg_q + 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cap = (state_q == RUN) && (flg_q < 7'(n));

  always_comb begin
    prod_d = prod_q;
    sum_d  = sum_q;
    vld_d  = vld_q;
    // Stage 1: lane products, or a zero bubble outside the load window
    for (int k = 0; k < n; k++) begin
      prod_d[1][k] = cap ? mul_trunc(signed'(bus.arr1[k*W +: W]), signed'(bus.arr2[k*W +: W]))
                         : '0;
    end
    sum_d[1] = prod_d[1][0];
    vld_d[1] = cap;
    // Stages 2..n: systolic chain, stage j folds in lane j-1
    for (int j = 2; j <= n; j++) begin
      prod_d[j] = prod_q[j-1];
      sum_d[j]  = sum_q[j-1] + prod_q[j-1][j-1];
      vld_d[j]  = vld_q[j-1];
    end
    // Stages n+1..2n-1: delay alignment
    for (int j = n + 1; j <= S; j++) begin
      sum_d[j] = sum_q[j-1];
      vld_d[j] = vld_q[j-1];
    end
    dpin_d      = sum_q[S];
    out_valid_d = vld_q[S];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flg_q       <= '0;
      dpin_q      <= '0;
      out_valid_q <= 1'b0;
      for (int j = 1; j <= n; j++)
        for (int k = 0; k < n; k++)
          prod_q[j][k] <= '0;
      for (int j = 1; j <= S; j++) begin
        sum_q[j] <= '0;
        vld_q[j] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      flg_q       <= flg_d;
      dpin_q      <= dpin_d;
      out_valid_q <= out_valid_d;
      prod_q      <= prod_d;
      sum_q       <= sum_d;
      vld_q       <= vld_d;
    end
  end

  assign bus.flg       = flg_q;
  assign bus.dpin      = dpin_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_row_dot_engine.sv
// Directed bench for row_dot_engine (N=31, n=3): inputs driven and outputs
// sampled on the falling edge, expected row sums hand-computed.
module tb_row_dot_engine;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [95:0] a1_t [3];
  logic [95:0] a2_t [3];
  logic [31:0] exp_t [3];

  row_dot_if #(.N(31), .n(3)) bus ();

  row_dot_engine #(.N(31), .n(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " flg"}, {25'd0, bus.flg}, 32'd0);
    chk({tag, " dpin"}, bus.dpin, 32'd0);
    chk({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic set_row(input int k, input int x0, input int x1, input int x2,
                         input int y0, input int y1, input int y2, input logic [31:0] e);
    a1_t[k]  = {32'(x2), 32'(x1), 32'(x0)};
    a2_t[k]  = {32'(y2), 32'(y1), 32'(y0)};
    exp_t[k] = e;
  endtask

  task automatic randomize_rows();
    bus.arr1 = {$urandom, $urandom, $urandom};
    bus.arr2 = {$urandom, $urandom, $urandom};
  endtask

  task automatic idle_cycles(input int m);
    bus.run = 1'b0;
    for (int i = 0; i < m; i++) begin
      randomize_rows();
      @(negedge clk);
      chk($sformatf("idle%0d", i), 32'd0, 32'd0 | {25'd0, bus.flg});
      chk($sformatf("idle%0d dpin", i), bus.dpin, 32'd0);
      chk($sformatf("idle%0d out_valid", i), {31'd0, bus.out_valid}, 32'd0);
    end
  endtask

  task automatic start_frame();
    bus.run = 1'b1;
    @(negedge clk);
  endtask

  // Entered at the falling edge of phase 0 in RUN; returns at the falling edge
  // after phase 8 (phase 0 of the next frame, or IDLE).
  task automatic do_frame(input string name, input bit run_after);
    for (int ph = 0; ph < 9; ph++) begin
      chk($sformatf("%s flg ph%0d", name, ph), {25'd0, bus.flg}, 32'(ph));
      chk($sformatf("%s dpin ph%0d", name, ph), bus.dpin, (ph >= 6) ? exp_t[ph-6] : 32'd0);
      chk($sformatf("%s out_valid ph%0d", name, ph), {31'd0, bus.out_valid},
          (ph >= 6) ? 32'd1 : 32'd0);
      if (ph < 3) begin
        bus.arr1 = a1_t[ph];
        bus.arr2 = a2_t[ph];
      end else begin
        randomize_rows();
      end
      if (ph == 1 && run_after) bus.run = 1'b0;
      if (ph == 3) bus.run = run_after;
      @(negedge clk);
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.run  = 1'b0;
    bus.arr1 = '0;
    bus.arr2 = '0;
    @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    idle_cycles(2);

    // Reset mid-frame at flg=4
    set_row(0, 9, 9, 9, 9, 9, 9, 32'd243);
    set_row(1, 1, 2, 3, 4, 5, 6, 32'd32);
    set_row(2, 5, 5, 5, 5, 5, 5, 32'd75);
    start_frame();
    for (int ph = 0; ph < 4; ph++) begin
      if (ph < 3) begin
        bus.arr1 = a1_t[ph];
        bus.arr2 = a2_t[ph];
      end
      @(negedge clk);
    end
    chk("midframe flg", {25'd0, bus.flg}, 32'd4);
    rst     = 1'b1;
    bus.run = 1'b0;
    #1;
    chk_quiet("async reset");
    @(negedge clk);
    chk_quiet("reset held");
    rst = 1'b0;
    idle_cycles(10);

    // Sobel column, run dropped at flg=3
    set_row(0, 10, 20, 30, -1, 0, 1, 32'h14);
    set_row(1,  5,  5,  9, -2, 0, 2, 32'h8);
    set_row(2,  0,  7,  3, -1, 0, 1, 32'h3);
    start_frame();
    do_frame("sobel", 1'b0);
    idle_cycles(4);

    // Wrap arithmetic and restart after stop
    set_row(0, 32'h7FFFFFFF, 0, 0, 2, 0, 0, 32'hFFFFFFFE);
    set_row(1, -1, -1, -1, 1, 1, 1, 32'hFFFFFFFD);
    set_row(2, int'(32'h80000000), int'(32'h80000000), 3, 1, 1, 5, 32'd15);
    start_frame();
    do_frame("wrap", 1'b0);
    idle_cycles(2);

    // Four back-to-back frames
    start_frame();
    set_row(0, 1, 2, 3, 1, 1, 1, 32'd6);
    set_row(1, 4, 5, 6, 1, 0, -1, 32'hFFFFFFFE);
    set_row(2, 2, 2, 2, 3, 4, 5, 32'd24);
    do_frame("f1", 1'b1);
    set_row(0, 7, 8, 9, 0, 1, 0, 32'd8);
    set_row(1, 100, -50, 25, 2, 2, 2, 32'd150);
    set_row(2, -3, -4, -5, -1, -1, -1, 32'd12);
    do_frame("f2", 1'b1);
    set_row(0, 1000, 1, 1, 1000, 0, 0, 32'hF4240);
    set_row(1, 0, 0, 0, 9, 9, 9, 32'd0);
    set_row(2, -7, 7, 0, 7, 7, 7, 32'd0);
    do_frame("f3", 1'b1);
    set_row(0, 32'h10000, 1, 0, 32'h10000, 5, 0, 32'd5);
    set_row(1, -1, -2, -3, 1, 2, 3, 32'hFFFFFFF2);
    set_row(2, 11, 13, 17, 2, 3, 5, 32'd146);
    do_frame("f4", 1'b0);
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/row_dot_engine.md
# row_dot_engine

Responder side of the row-streaming convolution interface. It owns the phase counter `flg`. It captures one packed pixel row (`arr1`) and one packed kernel row (`arr2`) per phase during the load window. It returns each row's n-lane dot product on `dpin` through a fixed-latency systolic multiply/accumulate chain, so the convolution driver accumulates row results during phases 2n..3n-1 of every 3n-phase frame.

## Interface
Parameters:
- `N`, 31: MSB index of a data word; word width is N+1.
- `n`, 3: kernel size (lanes per row, rows per frame); legal range 1..42 so that 3n-1 fits in 7 bits.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  level request to keep running frames.
- `arr1`  in  (N+1)*n  packed pixel row; lane k occupies bits [(k+1)(N+1)-1 : k(N+1)].
- `arr2`  in  (N+1)*n  packed kernel row; same lane packing.
- `flg`  out  7  phase counter, registered.
- `dpin`  out  N+1  row dot-product result, registered.
- `out_valid`  out  1  high while `dpin` carries a valid row result, registered.

## Operation
- States: IDLE, RUN. Reset state is IDLE.
- IDLE: `flg`=0 and no capture. Moves to RUN at the first edge where `run`=1. The phase `flg`=0 is then presented for one cycle in RUN.
- RUN: `flg` increments every edge.
  - At `flg`=3n-1, `flg` wraps to 0 and the block stays in RUN if `run`=1.
  - At `flg`=3n-1 with `run`=0, the block goes to IDLE with `flg`=0.
  - `run` is ignored mid-frame. Frames are never truncated.
- Capture: at the edge ending a cycle where state=RUN and `flg`=k<n, the block latches `arr1`/`arr2` as row k. In all other cycles a zero bubble enters the pipeline.
- Arithmetic, per lane:
  - Operands are two's-complement N+1 bits.
  - Product p_k = a_k*b_k, truncated to the low N+1 bits.
  - Row sum = sum of p_k, modulo 2^(N+1). There is no saturation and no overflow flag.
- Pipeline:
  - Stage 1: register the n lane products.
  - Stages 2..n: systolic add chain. Stage j adds lane j-1 into the running partial sum.
  - Stages n+1..2n-1: pure delay registers.
  - The final stage drives `dpin`.
- The pipeline always advances, including in IDLE, so in-flight rows drain.

## Timing
- Reset (async, immediate): `flg`=0, `dpin`=0, `out_valid`=0, state IDLE, all pipeline registers 0.
- Latency: a row captured at the edge ending phase k appears on `dpin` at the edge 2n-1 cycles later. It is therefore valid for the whole cycle where `flg`=2n+k.
  - The driver updates `arr1`/`arr2` on the falling edge and samples `dpin` on the falling edge, so both are stable at the sampling point.
- Steady state:
  - `dpin`=0 during phases 0..2n-1, because those slots carry bubbles.
  - `dpin` = row k result during phase 2n+k.
- `out_valid`=1 exactly in cycles where the `dpin` value originates from a captured row: RUN phases 2n..3n-1 of a frame whose load window was captured.
- Stop then restart:
  - After RUN→IDLE, the last frame's rows have already been consumed and the pipeline holds zeros.
  - A restart begins a clean frame at `flg`=0.
- Reset mid-frame: all partial results are discarded. After release, the first row is captured only in the next RUN frame.
- Back-to-back frames: with n=3, frame f's row 0 is captured at the edge ending phase 0. Frame f-1's rows exit during phases 6..8 of frame f-1, so frames never overlap.

## Test plan
- Reset/idle: assert `rst` mid-frame with `flg`=4. Then `flg`=0, `dpin`=0, `out_valid`=0 immediately and held while `run`=0.
- Single frame, n=3, Sobel column:
  - Rows: arr2 = [-1,0,1] with arr1 = [10,20,30]; arr2 = [-2,0,2] with arr1 = [5,5,9]; arr2 = [-1,0,1] with arr1 = [0,7,3].
  - Required: `dpin`=20, 8, 3 (0x14, 0x8, 0x3) at `flg`=6, 7, 8 with `out_valid`=1, and `dpin`=0 at `flg`=0..5.
- Wrap arithmetic: lane 0 = 0x7FFFFFFF*2, other lanes 0. Required: `dpin`=0xFFFFFFFE.
  - Lanes giving -1, -1, -1: required `dpin`=0xFFFFFFFD.
- Continuous run: hold `run`=1 for 4 frames with distinct rows per frame. `flg` must sequence 0..8 repeatedly, and each frame's three results must appear only in that frame's phases 6..8.
- Stop at boundary: drop `run` at `flg`=3. Required: the frame completes through `flg`=8, results are correct, `flg` stays 0 and state IDLE. Reassert `run` and the next frame starts cleanly.
- Ignored inputs: change `arr1`/`arr2` randomly during phases 3..8 and in IDLE. Results must be unaffected.
